// File: rtl/nec_ir_command_controller_pkg.sv
// Shared types and constants for the NEC IR command controller.
// Field offsets index the bit-reversed frame word, where bit 0 is the
// first bit received over the air.
package nec_ir_pkg;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        COMMIT = 2'd2
    } necState_t;

    // Bit positions of the four NEC fields inside the bit-reversed word.
    localparam int NEC_ADDR_LSB  = 0;
    localparam int NEC_NADDR_LSB = 8;
    localparam int NEC_CMD_LSB   = 16;
    localparam int NEC_NCMD_LSB  = 24;

    // Address key: {8'h00, addr} for standard frames, {naddr, addr} for extended.
    typedef logic [15:0] nec_key_t;

    // The receiver shifts the first bit into bit 31; NEC sends LSB first,
    // so reversing the word puts every field in natural bit order.
    function automatic logic [31:0] bitReverse32(input logic [31:0] raw);
        logic [31:0] rev;
        for (int i = 0; i < 32; i++) begin
            rev[i] = raw[31 - i];
        end
        return rev;
    endfunction

endpackage

// File: rtl/nec_ir_command_controller_if.sv
// Bus between the NEC receiver/effect side and the command controller.
//
// Handshakes:
//  - Frame input: frameStrobeIN is a one-cycle pulse; dataIN is only
//    meaningful in that cycle. There is no back-pressure; a strobe that
//    arrives while the controller is busy is dropped and counted as an error.
//  - Command output: cmdOUT is a valid command whenever cmdValidOUT=1.
//    A transfer happens on every rising clkIN edge where cmdValidOUT and
//    cmdReadyIN are both 1. cmdValidOUT does not depend on cmdReadyIN,
//    and cmdOUT/cmdValidOUT stay stable until the transfer happens.
interface nec_ir_command_controller_if;

    logic        frameStrobeIN;
    logic [31:0] dataIN;
    logic [7:0]  cmdOUT;
    logic        cmdValidOUT;
    logic        cmdReadyIN;
    logic        overflowOUT;
    logic [7:0]  errorCountOUT;

    // Side that delivers frames and consumes commands.
    modport master (
        output frameStrobeIN,
        output dataIN,
        output cmdReadyIN,
        input  cmdOUT,
        input  cmdValidOUT,
        input  overflowOUT,
        input  errorCountOUT
    );

    // The command controller itself.
    modport slave (
        input  frameStrobeIN,
        input  dataIN,
        input  cmdReadyIN,
        output cmdOUT,
        output cmdValidOUT,
        output overflowOUT,
        output errorCountOUT
    );

endinterface

// File: rtl/nec_ir_command_controller_fifo.sv
// Small first-word fall-through FIFO with registered head outputs.
// The head register is computed from next-state pointers so that rdData and
// valid are flops, not a read mux. A push and pop into an empty FIFO does not
// bypass: the pushed word appears on rdData the following cycle.
module nec_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clkIN,
    input  logic             nResetIN,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wrData,
    output logic [WIDTH-1:0] rdData,
    output logic             valid,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic [CNT_W-1:0] count;

    logic             doPush;
    logic             doPop;
    logic [PTR_W-1:0] rdPtrNext;
    logic [CNT_W-1:0] countNext;
    logic [WIDTH-1:0] headNext;

    // Wrap-around pointer increment that also works for non power-of-two depths.
    function automatic logic [PTR_W-1:0] advance(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);

    // Accepted operations, next read pointer/count and the word that becomes the head.
    always_comb begin
        doPop     = pop & ~empty;
        doPush    = push & (~full | doPop);
        rdPtrNext = doPop ? advance(rdPtr) : rdPtr;
        unique case ({doPush, doPop})
            2'b10:   countNext = count + CNT_W'(1);
            2'b01:   countNext = count - CNT_W'(1);
            default: countNext = count;
        endcase
        // The new head is the word being written only if it lands in the slot being exposed.
        if (doPush && (rdPtrNext == wrPtr)) begin
            headNext = wrData;
        end else begin
            headNext = mem[rdPtrNext];
        end
    end

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clkIN) begin
        if (doPush) begin
            mem[wrPtr] <= wrData;
        end
    end

    // Pointers, occupancy and the registered head (held while empty).
    always_ff @(posedge clkIN) begin
        if (!nResetIN) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            count  <= '0;
            rdData <= '0;
            valid  <= 1'b0;
        end else begin
            if (doPush) begin
                wrPtr <= advance(wrPtr);
            end
            rdPtr <= rdPtrNext;
            count <= countNext;
            valid <= (countNext != '0);
            if (countNext != '0) begin
                rdData <= headNext;
            end
        end
    end

endmodule

// File: rtl/nec_ir_command_controller.sv
// NEC IR command controller: validates decoded NEC frames, filters by
// address, suppresses key-hold repeats inside a hold-off window and queues
// the surviving 8-bit commands for the effect sequencer.
module nec_ir_command_controller
    import nec_ir_pkg::*;
#(
    parameter nec_key_t ADDRESS_FILTER = 16'h0000,
    parameter bit       FILTER_EN      = 1'b1,
    parameter int       HOLDOFF_CYCLES = 5_000_000
) (
    input  logic                          clkIN,
    input  logic                          nResetIN,
    nec_ir_command_controller_if.slave    bus,
    output necState_t                     stateOUT
);

    localparam int TIMER_W = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [TIMER_W-1:0] HOLDOFF_LOAD = TIMER_W'(HOLDOFF_CYCLES);

    necState_t           state;
    logic [31:0]         frameReg;
    logic [31:0]         frameWord;
    logic [7:0]          addrField;
    logic [7:0]          naddrField;
    logic [7:0]          cmdField;
    logic [7:0]          ncmdField;
    logic                integrityOk;
    logic                filterOk;
    nec_key_t            frameKey;

    nec_key_t            keyReg;
    logic [7:0]          cmdReg;
    logic                frameValid;
    logic [23:0]         lastKey;
    logic [TIMER_W-1:0]  holdoffTimer;

    logic                isDuplicate;
    logic                pushCmd;
    logic                reloadTimer;
    logic                busyStrobe;
    logic                integrityErr;
    logic [1:0]          errInc;
    logic [8:0]          errSum;
    logic [7:0]          errorCount;
    logic                overflow;

    logic                fifoPop;
    logic                fifoFull;
    logic                fifoEmpty;
    logic                fifoValid;
    logic [7:0]          fifoData;

    // Field extraction from the captured frame.
    assign frameWord   = bitReverse32(frameReg);
    assign addrField   = frameWord[NEC_ADDR_LSB  +: 8];
    assign naddrField  = frameWord[NEC_NADDR_LSB +: 8];
    assign cmdField    = frameWord[NEC_CMD_LSB   +: 8];
    assign ncmdField   = frameWord[NEC_NCMD_LSB  +: 8];

    // Only the command pair is an integrity check; a non-complemented
    // address pair just means the remote uses 16-bit extended addressing.
    assign integrityOk = (cmdField == ~ncmdField);
    assign frameKey    = (naddrField == ~addrField) ? {8'h00, addrField}
                                                    : {naddrField, addrField};
    assign filterOk    = !FILTER_EN || (frameKey == ADDRESS_FILTER);

    // A repeat of the last accepted key+command is suppressed only while the timer runs.
    assign isDuplicate  = ({keyReg, cmdReg} == lastKey) && (holdoffTimer != '0);
    assign pushCmd      = (state == COMMIT) && frameValid && !isDuplicate;
    assign reloadTimer  = (state == COMMIT) && frameValid;
    assign busyStrobe   = bus.frameStrobeIN && (state != IDLE);
    assign integrityErr = (state == DECODE) && !integrityOk;

    // Both error sources can fire in the same DECODE cycle; each counts once.
    assign errInc = {1'b0, busyStrobe} + {1'b0, integrityErr};
    assign errSum = {1'b0, errorCount} + {7'b0, errInc};

    // Controller sequencing: capture, decode, then commit or drop.
    always_ff @(posedge clkIN) begin
        if (!nResetIN) begin
            state      <= IDLE;
            frameReg   <= '0;
            keyReg     <= '0;
            cmdReg     <= '0;
            frameValid <= 1'b0;
            lastKey    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.frameStrobeIN) begin
                        frameReg <= bus.dataIN;
                        state    <= DECODE;
                    end
                end
                DECODE: begin
                    keyReg     <= frameKey;
                    cmdReg     <= cmdField;
                    frameValid <= integrityOk && filterOk;
                    state      <= COMMIT;
                end
                COMMIT: begin
                    if (pushCmd) begin
                        lastKey <= {keyReg, cmdReg};
                    end
                    frameValid <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Hold-off timer: reload on any accepted or suppressed frame, otherwise count down to 0.
    always_ff @(posedge clkIN) begin
        if (!nResetIN) begin
            holdoffTimer <= '0;
        end else if (reloadTimer) begin
            holdoffTimer <= HOLDOFF_LOAD;
        end else if (holdoffTimer != '0) begin
            holdoffTimer <= holdoffTimer - TIMER_W'(1);
        end
    end

    // Saturating count of rejected frames.
    always_ff @(posedge clkIN) begin
        if (!nResetIN) begin
            errorCount <= '0;
        end else begin
            errorCount <= errSum[8] ? 8'hFF : errSum[7:0];
        end
    end

    // Sticky overflow: a command was lost because the queue was full and not draining.
    always_ff @(posedge clkIN) begin
        if (!nResetIN) begin
            overflow <= 1'b0;
        end else if (pushCmd && fifoFull && !fifoPop) begin
            overflow <= 1'b1;
        end
    end

    assign fifoPop = !fifoEmpty && bus.cmdReadyIN;

    nec_cmd_fifo #(
        .DEPTH (4),
        .WIDTH (8)
    ) u_fifo (
        .clkIN    (clkIN),
        .nResetIN (nResetIN),
        .push     (pushCmd),
        .pop      (fifoPop),
        .wrData   (cmdReg),
        .rdData   (fifoData),
        .valid    (fifoValid),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    assign bus.cmdOUT        = fifoData;
    assign bus.cmdValidOUT   = fifoValid;
    assign bus.overflowOUT   = overflow;
    assign bus.errorCountOUT = errorCount;
    assign stateOUT          = state;

endmodule

// File: tb/tb_nec_ir_command_controller.sv
// Directed bench for the NEC IR command controller.
module tb_nec_ir_command_controller;
    import nec_ir_pkg::*;

    logic clkIN = 1'b0;
    logic nResetIN;
    necState_t state;
    necState_t state2;

    nec_ir_command_controller_if bus();
    nec_ir_command_controller_if bus2();

    nec_ir_command_controller #(
        .ADDRESS_FILTER (16'h0000),
        .FILTER_EN      (1'b1),
        .HOLDOFF_CYCLES (100)
    ) dut (
        .clkIN    (clkIN),
        .nResetIN (nResetIN),
        .bus      (bus.slave),
        .stateOUT (state)
    );

    nec_ir_command_controller #(
        .ADDRESS_FILTER (16'h0000),
        .FILTER_EN      (1'b0),
        .HOLDOFF_CYCLES (100)
    ) dut_nofilter (
        .clkIN    (clkIN),
        .nResetIN (nResetIN),
        .bus      (bus2.slave),
        .stateOUT (state2)
    );

    // Clock and watchdog.
    always #5 clkIN = ~clkIN;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int errors = 0;
    int checks = 0;
    int popCount = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [31:0] frame;
        logic        expValid;
        logic [7:0]  expCmd;
        logic [7:0]  expErr;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard: every pop must match the front of the expected queue.
    always @(negedge clkIN) begin
        #2;
        if (nResetIN === 1'b1 && bus.cmdValidOUT === 1'b1 && bus.cmdReadyIN === 1'b1) begin
            popCount++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected none", bus.cmdOUT);
            end else begin
                check("pop_order", {24'h0, bus.cmdOUT}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    // Driver tasks.
    task automatic doReset();
        @(negedge clkIN);
        nResetIN = 1'b0;
        bus.frameStrobeIN = 1'b0;
        bus2.frameStrobeIN = 1'b0;
        @(negedge clkIN);
        nResetIN = 1'b1;
        exp_q.delete();
        popCount = 0;
    endtask

    // One-cycle strobe; returns at the falling edge of the cycle after the strobe.
    task automatic pulse(input logic [31:0] d);
        @(negedge clkIN);
        bus.frameStrobeIN = 1'b1;
        bus.dataIN = d;
        @(negedge clkIN);
        bus.frameStrobeIN = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        check({tag, "_state"},    32'(state), 32'(IDLE));
        check({tag, "_valid"},    {31'h0, bus.cmdValidOUT}, 32'h0);
        check({tag, "_cmd"},      {24'h0, bus.cmdOUT}, 32'h0);
        check({tag, "_overflow"}, {31'h0, bus.overflowOUT}, 32'h0);
        check({tag, "_errcnt"},   {24'h0, bus.errorCountOUT}, 32'h0);
    endtask

    logic [31:0] ovfFrames[5];

    initial begin
        nResetIN = 1'b0;
        bus.frameStrobeIN = 1'b0;
        bus.dataIN = '0;
        bus.cmdReadyIN = 1'b0;
        bus2.frameStrobeIN = 1'b0;
        bus2.dataIN = '0;
        bus2.cmdReadyIN = 1'b0;

        // Single-frame vectors, each from reset with the consumer stalled.
        vecs[0] = '{32'h00FFA25D, 1'b1, 8'h45, 8'h00}; // standard addr 00, cmd 45
        vecs[1] = '{32'h00FFA25C, 1'b0, 8'h00, 8'h01}; // ncmd corrupt
        vecs[2] = '{32'h80FFA25D, 1'b0, 8'h00, 8'h00}; // extended key FF01, filtered
        vecs[3] = '{32'h00FF629D, 1'b1, 8'h46, 8'h00}; // cmd 46
        vecs[4] = '{32'h00FF02FD, 1'b1, 8'h40, 8'h00}; // cmd 40
        vecs[5] = '{32'h0000A25D, 1'b1, 8'h45, 8'h00}; // extended key 0000 matches filter
        vecs[6] = '{32'h807FA25D, 1'b0, 8'h00, 8'h00}; // standard key 0001, filtered
        vecs[7] = '{32'h00FFA2FF, 1'b0, 8'h00, 8'h01}; // ncmd FF, corrupt

        doReset();
        checkResetState("reset");

        for (int i = 0; i < 8; i++) begin
            doReset();
            pulse(vecs[i].frame);
            @(negedge clkIN);
            check($sformatf("vec%0d_early_valid", i), {31'h0, bus.cmdValidOUT}, 32'h0);
            @(negedge clkIN);
            check($sformatf("vec%0d_valid", i), {31'h0, bus.cmdValidOUT}, {31'h0, vecs[i].expValid});
            check($sformatf("vec%0d_cmd", i), {24'h0, bus.cmdOUT}, {24'h0, vecs[i].expCmd});
            check($sformatf("vec%0d_errcnt", i), {24'h0, bus.errorCountOUT}, {24'h0, vecs[i].expErr});
        end

        // Key hold: strobes 50 cycles apart, then a 150-cycle gap.
        doReset();
        bus.cmdReadyIN = 1'b1;
        exp_q.push_back(8'h45);
        exp_q.push_back(8'h45);
        for (int i = 0; i < 4; i++) begin
            pulse(32'h00FFA25D);
            repeat (48) @(negedge clkIN);
        end
        repeat (100) @(negedge clkIN);
        pulse(32'h00FFA25D);
        repeat (10) @(negedge clkIN);
        check("hold_pushes", 32'(popCount), 32'd2);
        check("hold_queue_left", 32'(exp_q.size()), 32'd0);
        check("hold_errcnt", {24'h0, bus.errorCountOUT}, 32'h0);
        bus.cmdReadyIN = 1'b0;

        // Integrity failures and saturation.
        doReset();
        pulse(32'h00FFA25C);
        repeat (3) @(negedge clkIN);
        check("bad_errcnt_1", {24'h0, bus.errorCountOUT}, 32'h1);
        for (int i = 0; i < 300; i++) begin
            pulse(32'h00FFA25C);
            repeat (2) @(negedge clkIN);
            if (i == 252) check("bad_errcnt_254", {24'h0, bus.errorCountOUT}, 32'hFE);
            if (i == 253) check("bad_errcnt_255", {24'h0, bus.errorCountOUT}, 32'hFF);
        end
        check("bad_errcnt_sat", {24'h0, bus.errorCountOUT}, 32'hFF);
        check("bad_no_push", {31'h0, bus.cmdValidOUT}, 32'h0);

        // Address filter disabled: the FF01 frame is accepted.
        doReset();
        @(negedge clkIN);
        bus2.frameStrobeIN = 1'b1;
        bus2.dataIN = 32'h80FFA25D;
        @(negedge clkIN);
        bus2.frameStrobeIN = 1'b0;
        repeat (2) @(negedge clkIN);
        check("nofilter_valid", {31'h0, bus2.cmdValidOUT}, 32'h1);
        check("nofilter_cmd", {24'h0, bus2.cmdOUT}, 32'h45);
        check("nofilter_errcnt", {24'h0, bus2.errorCountOUT}, 32'h0);
        check("nofilter_state", 32'(state2), 32'(IDLE));

        // Overflow: five distinct commands into a stalled four-entry queue.
        ovfFrames[0] = 32'h00FFA25D;
        ovfFrames[1] = 32'h00FF629D;
        ovfFrames[2] = 32'h00FFE21D;
        ovfFrames[3] = 32'h00FF22DD;
        ovfFrames[4] = 32'h00FF02FD;
        doReset();
        for (int i = 0; i < 5; i++) begin
            pulse(ovfFrames[i]);
            repeat (8) @(negedge clkIN);
            if (i == 3) check("ovf_not_yet", {31'h0, bus.overflowOUT}, 32'h0);
        end
        repeat (3) @(negedge clkIN);
        check("ovf_flag", {31'h0, bus.overflowOUT}, 32'h1);
        check("ovf_head_valid", {31'h0, bus.cmdValidOUT}, 32'h1);
        check("ovf_head_cmd", {24'h0, bus.cmdOUT}, 32'h45);
        exp_q.push_back(8'h45);
        exp_q.push_back(8'h46);
        exp_q.push_back(8'h47);
        exp_q.push_back(8'h44);
        @(negedge clkIN);
        bus.cmdReadyIN = 1'b1;
        repeat (4) @(negedge clkIN);
        check("drain_valid", {31'h0, bus.cmdValidOUT}, 32'h0);
        check("drain_pops", 32'(popCount), 32'd4);
        check("drain_queue_left", 32'(exp_q.size()), 32'd0);
        check("drain_cmd_held", {24'h0, bus.cmdOUT}, 32'h44);
        check("drain_ovf_sticky", {31'h0, bus.overflowOUT}, 32'h1);
        bus.cmdReadyIN = 1'b0;

        // Busy strobe: second strobe one cycle after the first.
        doReset();
        @(negedge clkIN);
        bus.frameStrobeIN = 1'b1;
        bus.dataIN = 32'h00FFA25D;
        @(negedge clkIN);
        check("busy_state_decode", 32'(state), 32'(DECODE));
        bus.dataIN = 32'h00FF629D;
        @(negedge clkIN);
        bus.frameStrobeIN = 1'b0;
        check("busy_errcnt", {24'h0, bus.errorCountOUT}, 32'h1);
        @(negedge clkIN);
        check("busy_valid", {31'h0, bus.cmdValidOUT}, 32'h1);
        check("busy_cmd", {24'h0, bus.cmdOUT}, 32'h45);
        repeat (5) @(negedge clkIN);
        check("busy_cmd_stable", {24'h0, bus.cmdOUT}, 32'h45);
        check("busy_errcnt_final", {24'h0, bus.errorCountOUT}, 32'h1);

        // Reset during DECODE discards the frame.
        @(negedge clkIN);
        bus.frameStrobeIN = 1'b1;
        bus.dataIN = 32'h00FF629D;
        @(negedge clkIN);
        bus.frameStrobeIN = 1'b0;
        check("rst_state_decode", 32'(state), 32'(DECODE));
        nResetIN = 1'b0;
        @(negedge clkIN);
        nResetIN = 1'b1;
        exp_q.delete();
        checkResetState("rst_mid");
        repeat (4) @(negedge clkIN);
        check("rst_no_push", {31'h0, bus.cmdValidOUT}, 32'h0);
        check("rst_state_idle", 32'(state), 32'(IDLE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
